// File: rtl/wb_uart_single.sv
// rtl/wb_uart_single.sv - Wishbone 128-bit single-word UART responder
// TX/RX 8N1 shifters with small FIFOs behind one aliased register word.
module wb_uart_single #(
    parameter int MSK        = 24,
    parameter int AW         = 32,
    parameter int DW         = 128,
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            tx,
    input  logic            rx,
    input  logic [AW-1:0]   i_wb_adr,
    input  logic [DW/8-1:0] i_wb_sel,
    input  logic            i_wb_we,
    input  logic [DW-1:0]   i_wb_dat,
    output logic [DW-1:0]   o_wb_dat,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    output logic            o_wb_ack,
    output logic            o_wb_err
);
    localparam int BW = $clog2(CLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLK_DIV / 2 - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [PW:0]   tx_cnt, rx_cnt;
    uart_state_t   tx_state, rx_state;
    logic [BW-1:0] tx_baud, rx_baud;
    logic [2:0]    tx_bit, rx_bit;
    logic [7:0]    tx_shift, rx_shift;
    logic [1:0]    rx_sync;
    logic          rx_prev, rx_overrun, frame_err;

    logic req, wr_req, rd_req, tx_full, tx_empty, rx_valid, rx_line;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_done, clr_ovr, clr_fe;
    logic [DW-1:0] rd_word;
    logic unused_bits;

    // Address is fully aliased; only the data/select lanes below carry meaning.
    assign unused_bits = ^{i_wb_adr, i_wb_sel, i_wb_dat, AW'(MSK)};

    assign rx_line  = rx_sync[1];
    assign req      = i_wb_cyc & i_wb_stb & ~o_wb_ack & ~o_wb_err;
    assign wr_req   = req & i_wb_we;
    assign rd_req   = req & ~i_wb_we;
    assign tx_full  = tx_cnt == FULL_CNT;
    assign tx_empty = tx_cnt == '0;
    assign rx_valid = rx_cnt != '0;
    assign tx_push  = wr_req & i_wb_sel[0] & ~tx_full;
    assign tx_pop   = ~tx_empty & ((tx_state == IDLE) | ((tx_state == STOP) & (tx_baud == BIT_LAST)));
    assign rx_pop   = rd_req & i_wb_sel[0] & rx_valid;
    assign rx_done  = (rx_state == STOP) & (rx_baud == BIT_LAST);
    // A pop in the same cycle frees the slot for the arriving byte.
    assign rx_push  = rx_done & rx_line & ((rx_cnt != FULL_CNT) | rx_pop);
    assign clr_ovr  = wr_req & i_wb_sel[4] & i_wb_dat[35];
    assign clr_fe   = wr_req & i_wb_sel[4] & i_wb_dat[37];

    always_comb begin
        rd_word     = '0;
        rd_word[7:0] = rx_valid ? rx_mem[rx_rp] : 8'h00;
        rd_word[32] = tx_full;
        rd_word[33] = tx_empty;
        rd_word[34] = rx_valid;
        rd_word[35] = rx_overrun;
        rd_word[36] = tx_state != IDLE;
        rd_word[37] = frame_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wb_ack   <= 1'b0;
            o_wb_err   <= 1'b0;
            o_wb_dat   <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            o_wb_ack   <= req & ~(i_wb_we & i_wb_sel[0] & tx_full);
            o_wb_err   <= wr_req & i_wb_sel[0] & tx_full;
            if (rd_req)
                o_wb_dat <= rd_word;
            rx_overrun <= (rx_done & rx_line & ~rx_push) | (rx_overrun & ~clr_ovr);
            frame_err  <= (rx_done & ~rx_line) | (frame_err & ~clr_fe);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp] <= i_wb_dat[7:0];
        if (rx_push)
            rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            tx_cnt <= tx_cnt + (PW+1)'(tx_push) - (PW+1)'(tx_pop);
            rx_cnt <= rx_cnt + (PW+1)'(rx_push) - (PW+1)'(rx_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx       <= 1'b1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= tx_mem[tx_rp];
                        tx       <= 1'b0;
                        tx_baud  <= '0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_baud == BIT_LAST) begin
                        tx_baud  <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= DATA;
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_baud == BIT_LAST) begin
                        tx_baud <= '0;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                default: begin
                    // Back-to-back frames: go straight to the next start bit.
                    if (tx_baud == BIT_LAST) begin
                        tx_baud <= '0;
                        if (tx_pop) begin
                            tx_shift <= tx_mem[tx_rp];
                            tx       <= 1'b0;
                            tx_state <= START;
                        end else begin
                            tx_state <= IDLE;
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_line;
            case (rx_state)
                IDLE: begin
                    // Edge-triggered, so a line stuck low after a framing error is ignored.
                    if (rx_prev & ~rx_line) begin
                        rx_baud  <= '0;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_baud == HALF_LAST) begin
                        rx_baud  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_line ? IDLE : DATA;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_baud == BIT_LAST) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_line, rx_shift[7:1]};
                        if (rx_bit == 3'd7)
                            rx_state <= STOP;
                        else
                            rx_bit <= rx_bit + 1'b1;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                default: begin
                    if (rx_baud == BIT_LAST) begin
                        rx_baud  <= '0;
                        rx_state <= IDLE;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_uart_single.sv
// tb/tb_wb_uart_single.sv - self-checking bench for wb_uart_single
// Bus vectors via a response scoreboard; serial TX decoded against a byte queue.
module tb_wb_uart_single;
    localparam int DIV = 8;
    localparam int DEP = 4;
    localparam logic [127:0] B33 = 128'h2_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;
    logic [31:0]  adr = '0;
    logic [15:0]  sel = '0;
    logic         we  = 1'b0;
    logic [127:0] wdat = '0;
    logic [127:0] rdat;
    logic         cyc = 1'b0, stb = 1'b0;
    logic         ack, err;

    always #5 clk = ~clk;

    wb_uart_single #(.MSK(24), .AW(32), .DW(128), .CLK_DIV(DIV), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .tx(tx), .rx(rx),
        .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we), .i_wb_dat(wdat),
        .o_wb_dat(rdat), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .o_wb_ack(ack), .o_wb_err(err)
    );

    typedef struct {
        bit           we;
        logic [15:0]  sel;
        logic [127:0] dat;
        bit           exp_err;
        bit           chk_dat;
        logic [127:0] exp_dat;
        string        name;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;
    vec_t sbq[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int starts[$];
    bit m_ovr = 0, m_ferr = 0;
    int cyc_n = 0;
    int last_resp_cyc = 0;
    bit mon_active = 0;
    int mon_cnt = 0;
    logic [9:0] mon_frame;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input bit w, input logic [15:0] s, input logic [127:0] d,
                                input bit e, input bit c, input logic [127:0] x, input string n);
        vec_t v;
        v.we = w; v.sel = s; v.dat = d; v.exp_err = e; v.chk_dat = c; v.exp_dat = x; v.name = n;
        return v;
    endfunction

    task automatic access(input vec_t v);
        vec_t e;
        bit got;
        got = 0;
        sbq.push_back(v);
        if (v.we && v.sel[0] && !v.exp_err) txq.push_back(v.dat[7:0]);
        cyc = 1; stb = 1; we = v.we; sel = v.sel; wdat = v.dat; adr = $urandom;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack || err) got = 1;
        end
        last_resp_cyc = cyc_n;
        cyc = 0; stb = 0; we = 0;
        e = sbq.pop_front();
        if (!got) check({e.name, "_timeout"}, 0, 1);
        else begin
            check({e.name, "_resp"}, {ack, err}, {~e.exp_err, e.exp_err});
            if (e.chk_dat) check({e.name, "_dat"}, rdat, e.exp_dat);
        end
    endtask

    function automatic logic [127:0] rx_expect();
        logic [127:0] w;
        w = B33;
        w[34] = rxq.size() != 0;
        w[35] = m_ovr;
        w[37] = m_ferr;
        if (rxq.size() != 0) w[7:0] = rxq[0];
        return w;
    endfunction

    task automatic rd_chk(input string name, input bit pop);
        access(mk(0, pop ? 16'h0001 : 16'h0000, '0, 0, 1, rx_expect(), name));
        if (pop && rxq.size() != 0) void'(rxq.pop_front());
    endtask

    task automatic w1c(input string name, input logic [127:0] bits);
        access(mk(1, 16'h0010, bits, 0, 0, '0, name));
        if (bits[35]) m_ovr = 0;
        if (bits[37]) m_ferr = 0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rx = 1;
        if (!stop) m_ferr = 1;
        else if (rxq.size() < DEP) rxq.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic wait_tx_drain(input string name);
        for (int k = 0; k < 800 && (txq.size() != 0 || mon_active); k++) @(posedge clk);
        #1;
        check(name, txq.size(), 0);
    endtask

    // Serial decoder: samples each bit centre, compares against queued bytes.
    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (rst) mon_active = 0;
        else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1;
                mon_cnt = 0;
                starts.push_back(cyc_n);
            end
        end else begin
            mon_cnt = mon_cnt + 1;
            if (mon_cnt % 8 == 4) mon_frame[mon_cnt / 8] = tx;
            if (mon_cnt == 79) begin
                mon_active = 0;
                if (txq.size() == 0) check("tx_unexpected_frame", mon_frame, 10'h3FF);
                else check("tx_frame", mon_frame, {1'b1, txq.pop_front(), 1'b0});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t tbl[7];
    int sidx, push_cyc, bs, d;

    initial begin
        tbl[0] = mk(0, 16'h0001, '0, 0, 1, B33, "rd_reset");
        tbl[1] = mk(1, 16'h0002, 128'hFF, 0, 0, '0, "wr_sel1_noop");
        tbl[2] = mk(0, 16'hFFFF, '0, 0, 1, B33, "rd_all_sel_empty");
        tbl[3] = mk(1, 16'h0010, 128'h28_0000_0000, 0, 0, '0, "w1c_idle");
        tbl[4] = mk(0, 16'h0000, '0, 0, 1, B33, "rd_sel_none");
        tbl[5] = mk(1, 16'h0001, 128'h55, 0, 0, '0, "push_55");
        tbl[6] = mk(0, 16'h0000, '0, 0, 1, 128'h12_0000_0000, "rd_busy");

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_dat", rdat, 0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;

        sidx = 0; push_cyc = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) sidx = starts.size();
            access(tbl[i]);
            if (i == 5) push_cyc = last_resp_cyc;
        end
        wait_tx_drain("tx_55_drain");
        if (starts.size() > sidx) begin
            d = starts[sidx] - push_cyc;
            check("tx_start_latency", (d >= 1 && d <= 3), 1);
        end else check("tx_start_seen", starts.size(), sidx + 1);

        // Burst of pushes: first frame dequeues early, so five fit; the sixth errs.
        repeat (5) @(posedge clk);
        #1;
        bs = starts.size();
        access(mk(1, 16'h0001, 128'h11, 0, 0, '0, "burst_push1"));
        access(mk(1, 16'h0001, 128'h22, 0, 0, '0, "burst_push2"));
        access(mk(1, 16'h0001, 128'h33, 0, 0, '0, "burst_push3"));
        access(mk(1, 16'h0001, 128'h44, 0, 0, '0, "burst_push4"));
        access(mk(1, 16'h0001, 128'h5A, 0, 0, '0, "burst_push5"));
        access(mk(1, 16'h0001, 128'h66, 1, 0, '0, "burst_push6_full"));
        access(mk(0, 16'h0000, '0, 0, 1, 128'h11_0000_0000, "rd_full"));
        wait_tx_drain("burst_drain");
        if (starts.size() >= bs + 5) begin
            for (int k = 1; k < 5; k++) check("burst_frame_gap", starts[bs + k] - starts[bs + k - 1], 80);
        end else check("burst_frames", starts.size() - bs, 5);

        repeat (5) @(posedge clk);
        #1;
        send_rx(8'hA3, 1);
        repeat (4) @(posedge clk);
        #1;
        rd_chk("rx_a3_peek", 0);
        rd_chk("rx_a3_pop", 1);
        rd_chk("rx_after_pop", 0);

        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1);
        repeat (4) @(posedge clk);
        #1;
        rd_chk("ovr_status", 0);
        w1c("clr_ovr", 128'h08_0000_0000);
        rd_chk("ovr_cleared", 0);
        for (int i = 0; i < 4; i++) rd_chk("ovr_pop", 1);
        rd_chk("ovr_empty", 0);

        send_rx(8'h77, 0);
        repeat (DIV) @(posedge clk);
        #1;
        rd_chk("ferr_status", 0);
        w1c("clr_ferr", 128'h20_0000_0000);
        rd_chk("ferr_cleared", 0);
        send_rx(8'h3C, 1);
        repeat (4) @(posedge clk);
        #1;
        rd_chk("rx_recover_pop", 1);

        rx = 0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1;
        repeat (20) @(posedge clk);
        #1;
        rd_chk("glitch_reject", 0);

        access(mk(1, 16'h0001, 128'h0F, 0, 0, '0, "push_before_rst"));
        repeat (30) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("rst_mid_tx", tx, 1);
        txq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rd_chk("rst_status", 0);
        repeat (100) @(posedge clk);
        #1;
        check("tx_idle_after_rst", tx, 1);
        check("tx_queue_empty", txq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/wb_uart_single.md
# wb_uart_single

Wishbone responder that attaches a UART to the system crossbar alongside the SRAM and GPIO slaves. It drives the FPGA `tx` pin and samples the `rx` pin. It moves 8N1 bytes through a transmit FIFO and a receive FIFO. Software sees one 128-bit register word, aliased across the whole slave window, and reaches it through the same 128-bit single-cycle Wishbone access the core uses for every other slave.

## Interface
- `MSK`, 24: address bits below which the slave window aliases. Address bits are otherwise ignored.
- `AW`, 32: Wishbone address width.
- `DW`, 128: Wishbone data width. Fixed at 128; the register layout depends on it.
- `CLK_DIV`, 434: clk cycles per UART bit. Must be ≥ 4.
- `FIFO_DEPTH`, 4: entries per FIFO. Power of 2, ≥ 2.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tx` out 1: UART serial out. Idle level is 1.
- `rx` in 1: UART serial in. Asynchronous to `clk`.
- `i_wb_adr` in AW: address (ignored below MSK).
- `i_wb_sel` in DW/8: byte lane selects.
- `i_wb_we` in 1: write enable.
- `i_wb_dat` in DW: write data.
- `o_wb_dat` out DW: read data.
- `i_wb_cyc` in 1: bus cycle.
- `i_wb_stb` in 1: strobe.
- `o_wb_ack` out 1: acknowledge.
- `o_wb_err` out 1: error termination.

## Operation
Register word fields:
- Bits [7:0], write: TX data. Read: RX data.
- Bits [39:32], status:
  - b32 tx_full
  - b33 tx_empty
  - b34 rx_valid (RX FIFO not empty)
  - b35 rx_overrun
  - b36 tx_busy (shifter active)
  - b37 frame_err
- All other read bits are 0.

Bus accesses:
- A request is `i_wb_cyc & i_wb_stb` while `o_wb_ack` and `o_wb_err` are both 0.
- Write with sel[0]: push `i_wb_dat[7:0]` into the TX FIFO. If the TX FIFO is full at the request, pulse `o_wb_err` instead of `o_wb_ack`. The FIFO is unchanged.
- Write with sel[4]: write-1-to-clear. Bit 35 clears rx_overrun; bit 37 clears frame_err.
- Read: `o_wb_dat` gets status plus the RX FIFO head, or 0 in [7:0] when empty. If sel[0] is set and the FIFO is not empty, pop the head. A read of an empty FIFO is acked normally and pops nothing.
- Any other sel combination is acked with no side effect.

TX state machine (IDLE, START, DATA, STOP):
- IDLE: when the FIFO is not empty, pop the head, load the shifter, and enter START.
- START: drive 0 for CLK_DIV cycles, then enter DATA.
- DATA: shift 8 bits LSB first, CLK_DIV cycles each, then enter STOP.
- STOP: drive 1 for CLK_DIV cycles. If the FIFO is not empty at the end of STOP, go directly to START with no idle gap; otherwise return to IDLE.

RX path:
- `rx` passes through a 2-flop synchronizer.
- RX state machine (IDLE, START, DATA, STOP):
  - IDLE: a falling edge enters START.
  - START: wait CLK_DIV/2 cycles (integer division), then resample. If the line is 1, return to IDLE (glitch reject). Otherwise sample 8 data bits at CLK_DIV intervals.
  - STOP: sample the stop bit at CLK_DIV after the last data bit.
- Stop bit = 1: push the byte into the RX FIFO. If the FIFO is full, drop the byte and set rx_overrun.
- Stop bit = 0: drop the byte, set frame_err, and wait for the line to return to 1 before leaving IDLE.

## Timing
- Reset values:
  - `tx` = 1
  - `o_wb_ack` = 0, `o_wb_err` = 0, `o_wb_dat` = 0
  - both FIFOs empty, all status flags 0, both state machines in IDLE
- Bus response:
  - Ack/err is registered and asserts exactly 1 cycle after the request cycle, for exactly 1 cycle.
  - The request held through the ack cycle is not re-serviced.
  - The next access can start the cycle after ack. Peak rate is one access every 2 cycles.
- `o_wb_dat` is valid in the ack cycle and holds until the next read ack.
- TX latency: the start bit begins ≤ 2 cycles after the push ack when the block was idle. One frame is exactly 10·CLK_DIV cycles.
- RX latency: rx_valid is set ≤ CLK_DIV + 3 cycles after the midpoint of the stop bit.
- Simultaneous events on a full FIFO:
  - RX pop and RX byte completion in the same cycle: pop wins the slot, the new byte is stored, no overrun.
  - TX push on a full FIFO is decided on the registered count at the request, even if the transmitter dequeues in the same cycle, so the response is err.
- Reset mid-frame: `tx` returns to 1 immediately, and FIFO contents are discarded.

## Test plan
Bench uses CLK_DIV=8, FIFO_DEPTH=4.
- Reset, then read the word → `o_wb_dat`=0 except b33=1. `tx`=1 throughout.
- Write 0x55 with sel[0] → ack 1 cycle later. Then `tx` shows 0, 1,0,1,0,1,0,1,0, 1, each 8 cycles, 80 cycles total.
- Push 5 bytes back-to-back while TX is idle → the first 4 are acked. The 5th is acked too, because the first byte has already left the FIFO. An immediate 6th push while tx_full=1 → err. Frames are contiguous with no idle gap.
- Drive 0xA3 into `rx` → rx_valid=1. A read with sel[0] returns [7:0]=0xA3 and rx_valid=0 afterwards.
- Drive 5 frames into `rx` with no reads → the first 4 are stored and rx_overrun=1. A write of bit 35 with sel[4] clears it. A frame with stop bit 0 sets frame_err and stores nothing.
- A 2-cycle low glitch on `rx` stores no byte and sets no flags. Assert `rst` mid-TX frame → `tx`=1 on the next cycle and tx_empty=1.
